// File: rtl/seg7_pkg.sv
// seg7_pkg: glyph constants and code decoder for seg7_scan_driver; define SEG7_HEX_EN for A-F glyphs
package seg7_pkg;
  localparam int SEG_BIT_A = 0;
  localparam int SEG_BIT_B = 1;
  localparam int SEG_BIT_C = 2;
  localparam int SEG_BIT_D = 3;
  localparam int SEG_BIT_E = 4;
  localparam int SEG_BIT_F = 5;
  localparam int SEG_BIT_G = 6;
  localparam int SEG_W = SEG_BIT_G + 1;
  typedef logic [SEG_W-1:0] seg_t;
  localparam seg_t SEG_0     = 7'b1000000;
  localparam seg_t SEG_1     = 7'b1111001;
  localparam seg_t SEG_2     = 7'b0100100;
  localparam seg_t SEG_3     = 7'b0110000;
  localparam seg_t SEG_4     = 7'b0011001;
  localparam seg_t SEG_5     = 7'b0010010;
  localparam seg_t SEG_6     = 7'b0000010;
  localparam seg_t SEG_7     = 7'b1111000;
  localparam seg_t SEG_8     = 7'b0000000;
  localparam seg_t SEG_9     = 7'b0010000;
  localparam seg_t SEG_A     = 7'b0001000;
  localparam seg_t SEG_B     = 7'b0000011;
  localparam seg_t SEG_C     = 7'b1000110;
  localparam seg_t SEG_D     = 7'b0100001;
  localparam seg_t SEG_E     = 7'b0000110;
  localparam seg_t SEG_F     = 7'b0001110;
  localparam seg_t SEG_BLANK = 7'b1111111;
  function automatic seg_t seg7_decode(input logic [3:0] code);
    case (code)
      4'h0: return SEG_0;
      4'h1: return SEG_1;
      4'h2: return SEG_2;
      4'h3: return SEG_3;
      4'h4: return SEG_4;
      4'h5: return SEG_5;
      4'h6: return SEG_6;
      4'h7: return SEG_7;
      4'h8: return SEG_8;
      4'h9: return SEG_9;
`ifdef SEG7_HEX_EN
      4'hA: return SEG_A;
      4'hB: return SEG_B;
      4'hC: return SEG_C;
      4'hD: return SEG_D;
      4'hE: return SEG_E;
      4'hF: return SEG_F;
`endif
      default: return SEG_BLANK;
    endcase
  endfunction
endpackage

// File: rtl/seg7_glyph.sv
// seg7_glyph: combinational digit code to active-low segment pattern
module seg7_glyph
  import seg7_pkg::*;
(
  input  logic [3:0] code_i,
  output seg_t       seg_o
);
  assign seg_o = seg7_decode(code_i);
endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: double-buffered, frame-synchronous N-digit common-anode 7-seg scanner
// Hex glyphs for codes 10-15 are enabled by defining SEG7_HEX_EN.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 50000
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic                load_i,
  input  logic [4*DIGITS-1:0] bcd_i,
  input  logic [DIGITS-1:0]   dp_i,
  input  logic                blank_lz_i,
  output seg_t                seg_o,
  output logic                dp_o,
  output logic [DIGITS-1:0]   an_o,
  output logic                pending_o,
  output logic                frame_tick_o
);
  localparam int PW = $clog2(REFRESH_DIV);
  localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
  logic [PW-1:0]       presc_q, presc_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [4*DIGITS-1:0] bcd_disp_q, bcd_disp_d, bcd_pend_q, bcd_pend_d;
  logic [DIGITS-1:0]   dp_disp_q, dp_disp_d, dp_pend_q, dp_pend_d;
  logic                pend_q, pend_d, tick_q, tick_d, dp_q, dp_d;
  logic [DIGITS-1:0]   an_q, an_d;
  seg_t                seg_q, seg_d, glyph;
  logic [3:0]          code;
  logic                slot_end, last_digit, upper_nz, blank;
  // The frame boundary is the FRAME_TICK cycle, so a coincident LOAD lands in the frame it starts.
  always_comb begin
    slot_end   = presc_q == PW'(REFRESH_DIV - 1);
    last_digit = idx_q == IW'(DIGITS - 1);
    presc_d    = slot_end ? '0 : presc_q + 1'b1;
    idx_d      = slot_end ? (last_digit ? '0 : idx_q + 1'b1) : idx_q;
    tick_d     = slot_end && last_digit;
    bcd_disp_d = tick_q ? (load_i ? bcd_i : (pend_q ? bcd_pend_q : bcd_disp_q)) : bcd_disp_q;
    dp_disp_d  = tick_q ? (load_i ? dp_i : (pend_q ? dp_pend_q : dp_disp_q)) : dp_disp_q;
    bcd_pend_d = load_i ? bcd_i : bcd_pend_q;
    dp_pend_d  = load_i ? dp_i : dp_pend_q;
    pend_d     = !tick_q && (load_i || pend_q);
    code       = bcd_disp_d[{idx_q, 2'b00} +: 4];
    upper_nz   = 1'b0;
    for (int j = 0; j < DIGITS; j++)
      upper_nz = upper_nz | ((j >= int'(idx_q)) && (bcd_disp_d[4*j +: 4] != 4'h0));
    blank      = blank_lz_i && (idx_q != '0) && !upper_nz;
    seg_d      = presc_q == '0 ? (blank ? SEG_BLANK : glyph) : seg_q;
    dp_d       = presc_q == '0 ? ~dp_disp_d[idx_q] : dp_q;
    an_d       = presc_q == '0 ? '1 : ~(DIGITS'(1) << idx_q);
  end
  seg7_glyph u_glyph (
    .code_i (code),
    .seg_o  (glyph)
  );
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      presc_q    <= '0;
      idx_q      <= '0;
      bcd_disp_q <= '0;
      dp_disp_q  <= '0;
      bcd_pend_q <= '0;
      dp_pend_q  <= '0;
      pend_q     <= 1'b0;
      tick_q     <= 1'b0;
      seg_q      <= SEG_BLANK;
      dp_q       <= 1'b1;
      an_q       <= '1;
    end else begin
      presc_q    <= presc_d;
      idx_q      <= idx_d;
      bcd_disp_q <= bcd_disp_d;
      dp_disp_q  <= dp_disp_d;
      bcd_pend_q <= bcd_pend_d;
      dp_pend_q  <= dp_pend_d;
      pend_q     <= pend_d;
      tick_q     <= tick_d;
      seg_q      <= seg_d;
      dp_q       <= dp_d;
      an_q       <= an_d;
    end
  end
  assign seg_o        = seg_q;
  assign dp_o         = dp_q;
  assign an_o         = an_q;
  assign pending_o    = pend_q;
  assign frame_tick_o = tick_q;
endmodule
